alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Rst_n  input  1  reset; synchronous, active-low.
REQ-003 In_valid  input  1  operation request valid.
REQ-004 In_ready  output  1  block can accept an operation; high only in IDLE.
REQ-005 ALUctr  input  4  operation code, same encoding the ALU control decoder produces (table in REQ-012).
REQ-006 A  input  32  operand A (rs).
REQ-007 B  input  32  operand B (rt or immediate, already extended).
REQ-008 Shamt  input  5  shift amount for shift ops; ignored otherwise.
REQ-009 Out_valid  output  1  Result/flags valid; high only in DONE.
REQ-010 Out_ready  input  1  consumer accepts result.
REQ-011 Result  output  32;  Zero  output  1 (Result==0);  Overflow  output  1;  Illegal  output  1.

Function
REQ-012 ALUctr decode: 0000 addu, 0001 add, 0010 or, 0011 and, 0100 subu, 0101 sub, 0110 xor, 0111 nor, 1000 slt (signed), 1001 sltu, 1010 sll, 1011 srl, 1100 sra, 1101 lui, 1110/1111 illegal.
REQ-013 FSM states IDLE, SHIFT, DONE; one-hot or binary encoding free.
REQ-014 Accept = In_valid & In_ready at a rising edge (edge E0); A, B, Shamt, ALUctr captured at E0, need not be held afterwards.
REQ-015 IDLE, accept, non-shift op -> DONE at E0; Result/flags registered at E0, Out_valid high from E0.
REQ-016 IDLE, accept, shift op, Shamt==0 -> DONE at E0, Result=B.
REQ-017 IDLE, accept, shift op, Shamt=n>0 -> SHIFT; working reg=B, count=n; each SHIFT edge shifts working reg by one bit (sll: zero in at LSB; srl: zero in at MSB; sra: B[31] replicated) and decrements count; edge with count==1 -> DONE; Out_valid high from edge E0+n.
REQ-018 lui: Result = {B[15:0], 16'h0000}, single-cycle path.
REQ-019 add/addu/sub/subu modulo 2^32; slt/sltu Result = 32'h1 or 32'h0.
REQ-020 Overflow = 1 only for add/sub with signed overflow (operands same sign / differing sign for sub, result sign differs from A); Result still written with wrapped sum; 0 for all other ops.
REQ-021 Illegal op: Result=0, Zero=1, Illegal=1, Overflow=0; same latency as REQ-015.
REQ-022 DONE: Result, Zero, Overflow, Illegal held stable until edge with Out_ready=1 -> IDLE; Out_valid low from that edge.
REQ-023 In_ready=0 in SHIFT and DONE; In_valid there ignored, no queueing; peak throughput one op per two cycles.
REQ-024 Out_ready outside DONE has no effect.
REQ-025 Flags and Result change only on the DONE-entry edge; not updated during SHIFT.

Reset
REQ-026 Rst_n=0 at an edge -> state IDLE, Result=0, Zero=0, Overflow=0, Illegal=0, Out_valid=0, working reg and count=0; In_ready=1 after the first edge with Rst_n=1.
REQ-027 Reset in SHIFT or DONE aborts; no Out_valid for the aborted op; reset priority over all other inputs.

Verification
REQ-028 add A=7FFFFFFF, B=1, accept at E0 -> Out_valid from E0, Result=80000000, Overflow=1, Zero=0.
REQ-029 sra B=80000000, Shamt=4, accept E0 -> In_ready=0 E0..E0+3, Out_valid from E0+4, Result=F8000000.
REQ-030 subu A=B=12345678 with Out_ready held 0 for 3 cycles -> Result=0, Zero=1 held stable 3 cycles; IDLE and In_ready=1 one edge after Out_ready=1.
REQ-031 ALUctr=1110 -> Result=0, Illegal=1, Zero=1; following slt A=FFFFFFFF, B=1 -> Result=1, Illegal=0; sltu same operands -> Result=0.
REQ-032 sll Shamt=20 accepted, Rst_n=0 at E0+5 -> IDLE, Out_valid never asserted, all outputs 0; In_valid during SHIFT ignored.
REQ-033 sll Shamt=0, B=ABCD0000 -> Out_valid from E0, Result=ABCD0000; lui B=0000BEEF -> BEEF0000.

Source files
------------

// File: rtl/alu_exec.sv
// Multi-cycle ALU execute stage: single-cycle arithmetic/logic ops and
// bit-serial shifts, with a valid/ready handshake on both sides.
module alu_exec (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [3:0]  i_aluctr,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [4:0]  i_shamt,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_result,
    output logic        o_zero,
    output logic        o_overflow,
    output logic        o_illegal
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_work;
    logic [4:0]          r_cnt;
    logic [3:0]          r_op;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;
    logic                r_overflow;
    logic                r_illegal;

    logic signed [DATA_W-1:0] w_a_s;
    logic signed [DATA_W-1:0] w_b_s;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_ovf;
    logic                w_alu_ill;
    logic                w_is_shift;
    logic                w_accept;
    logic [DATA_W-1:0]   w_shifted;

    // One-bit step of the serial shifter; the op selects the fill bit.
    function automatic logic [DATA_W-1:0] shift_one(input logic [3:0] op,
                                                    input logic [DATA_W-1:0] v);
        case (op)
            4'b1010: shift_one = {v[DATA_W-2:0], 1'b0};
            4'b1011: shift_one = {1'b0, v[DATA_W-1:1]};
            default: shift_one = {v[DATA_W-1], v[DATA_W-1:1]};
        endcase
    endfunction

    assign w_a_s      = i_a;
    assign w_b_s      = i_b;
    assign w_sum      = i_a + i_b;
    assign w_diff     = i_a - i_b;
    assign w_is_shift = (i_aluctr == 4'b1010) || (i_aluctr == 4'b1011) ||
                        (i_aluctr == 4'b1100);
    assign w_accept   = i_in_valid && (r_state == S_IDLE);
    assign w_shifted  = shift_one(r_op, r_work);

    // Shift opcodes land here only with a zero shift amount, so they pass B.
    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        w_alu_ill = 1'b0;
        case (i_aluctr)
            4'b0000: w_alu_res = w_sum;
            4'b0001: begin
                w_alu_res = w_sum;
                w_alu_ovf = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
            end
            4'b0010: w_alu_res = i_a | i_b;
            4'b0011: w_alu_res = i_a & i_b;
            4'b0100: w_alu_res = w_diff;
            4'b0101: begin
                w_alu_res = w_diff;
                w_alu_ovf = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
            end
            4'b0110: w_alu_res = i_a ^ i_b;
            4'b0111: w_alu_res = ~(i_a | i_b);
            4'b1000: w_alu_res = {{(DATA_W-1){1'b0}}, (w_a_s < w_b_s)};
            4'b1001: w_alu_res = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
            4'b1010, 4'b1011, 4'b1100: w_alu_res = i_b;
            4'b1101: w_alu_res = {i_b[15:0], 16'h0000};
            default: w_alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_in_valid)
                         w_next = (w_is_shift && (i_shamt != 5'd0)) ? S_SHIFT : S_DONE;
            S_SHIFT: if (r_cnt == 5'd1) w_next = S_DONE;
            S_DONE:  if (i_out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready  = (r_state == S_IDLE);
        o_out_valid = (r_state == S_DONE);
    end

    // Result and flags are written only on the edge that enters DONE.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_work     <= '0;
            r_cnt      <= '0;
            r_op       <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_accept) begin
            if (w_is_shift && (i_shamt != 5'd0)) begin
                r_work <= i_b;
                r_cnt  <= i_shamt;
                r_op   <= i_aluctr;
            end else begin
                r_result   <= w_alu_res;
                r_zero     <= (w_alu_res == '0);
                r_overflow <= w_alu_ovf;
                r_illegal  <= w_alu_ill;
            end
        end else if (r_state == S_SHIFT) begin
            r_work <= w_shifted;
            r_cnt  <= r_cnt - 5'd1;
            if (r_cnt == 5'd1) begin
                r_result   <= w_shifted;
                r_zero     <= (w_shifted == '0);
                r_overflow <= 1'b0;
                r_illegal  <= 1'b0;
            end
        end
    end

    assign o_result   = r_result;
    assign o_zero     = r_zero;
    assign o_overflow = r_overflow;
    assign o_illegal  = r_illegal;
endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed corner cases followed by random
// operations compared against an arithmetic reference model.
module tb_alu_exec;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluctr;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero, overflow, illegal;

    int checks = 0;
    int errors = 0;

    alu_exec dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_aluctr(aluctr), .i_a(a), .i_b(b), .i_shamt(shamt),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_result(result), .o_zero(zero), .o_overflow(overflow), .o_illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: results from signed/unsigned integer arithmetic on the whole operands.
    task automatic ref_alu(input logic [3:0] op, input logic [31:0] ra, input logic [31:0] rb,
                           input logic [4:0] sh, output logic [31:0] res,
                           output logic ovf, output logic ill);
        longint sa, sb, s;
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        ovf = 1'b0;
        ill = 1'b0;
        res = 32'h0;
        case (op)
            4'd0, 4'd1: begin
                s = sa + sb;
                res = s[31:0];
                if (op == 4'd1) ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4, 4'd5: begin
                s = sa - sb;
                res = s[31:0];
                if (op == 4'd5) ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2:  res = ra | rb;
            4'd3:  res = ra & rb;
            4'd6:  res = ra ^ rb;
            4'd7:  res = ~(ra | rb);
            4'd8:  res = (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  res = (longint'(ra) < longint'(rb)) ? 32'd1 : 32'd0;
            4'd10: res = rb << sh;
            4'd11: res = rb >> sh;
            4'd12: res = $unsigned($signed(rb) >>> sh);
            4'd13: res = rb * 32'h10000;
            default: ill = 1'b1;
        endcase
    endtask

    task automatic drive_garbage();
        in_valid = 1'b1;
        aluctr   = 4'($urandom);
        a        = $urandom;
        b        = $urandom;
        shamt    = 5'($urandom);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] oa, input logic [31:0] ob,
                          input logic [4:0] sh, input int hold);
        logic [31:0] er;
        logic eo, ei;
        int lat, c;
        ref_alu(op, oa, ob, sh, er, eo, ei);
        lat = (op >= 4'd10 && op <= 4'd12) ? int'(sh) : 0;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        aluctr    = op;
        a         = oa;
        b         = ob;
        shamt     = sh;
        out_ready = 1'b0;
        @(negedge clk);
        drive_garbage();
        c = 0;
        while (out_valid !== 1'b1 && c < 40) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            out_ready = 1'($urandom);
            @(negedge clk);
            drive_garbage();
            c++;
        end
        out_ready = 1'b0;
        check("latency", c, lat);
        check("in_ready_done", 32'(in_ready), 32'd0);
        check("result", result, er);
        check("zero", 32'(zero), 32'(er == 32'h0));
        check("overflow", 32'(overflow), 32'(eo));
        check("illegal", 32'(illegal), 32'(ei));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            drive_garbage();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", result, er);
            check("hold_flags", {29'd0, zero, overflow, illegal},
                  {29'd0, (er == 32'h0), eo, ei});
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] sp [6];
        sp = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h12345678};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aluctr    = 4'h0;
        a         = 32'h0;
        b         = 32'h0;
        shamt     = 5'h0;
        repeat (2) @(negedge clk);
        check("rst_out", {28'd0, out_valid, zero, overflow, illegal}, 32'd0);
        check("rst_result", result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_op(4'd1,  32'h7FFFFFFF, 32'h00000001, 5'd0, 1);
        run_op(4'd12, 32'h0,        32'h80000000, 5'd4, 1);
        run_op(4'd4,  32'h12345678, 32'h12345678, 5'd0, 3);
        run_op(4'd14, 32'h11111111, 32'h22222222, 5'd0, 1);
        run_op(4'd8,  32'hFFFFFFFF, 32'h00000001, 5'd0, 0);
        run_op(4'd9,  32'hFFFFFFFF, 32'h00000001, 5'd0, 0);
        run_op(4'd10, 32'h0,        32'hABCD0000, 5'd0, 0);
        run_op(4'd13, 32'h0,        32'h0000BEEF, 5'd7, 0);
        run_op(4'd5,  32'h80000000, 32'h00000001, 5'd0, 0);
        run_op(4'd11, 32'h0,        32'h80000001, 5'd31, 1);

        // Abort a long shift with reset mid-flight.
        @(negedge clk);
        in_valid = 1'b1;
        aluctr   = 4'd10;
        a        = 32'h0;
        b        = 32'h00000001;
        shamt    = 5'd20;
        @(negedge clk);
        drive_garbage();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_garbage();
            check("abort_busy", {30'd0, out_valid, in_ready}, 32'd0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_out", {28'd0, out_valid, zero, overflow, illegal}, 32'd0);
        check("abort_result", result, 32'h0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        check("abort_in_ready", 32'(in_ready), 32'd1);

        for (int n = 0; n < 60; n++) begin
            run_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
                   5'($urandom_range(0, 31)), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
